pwm_switch_conditioner: RTL and testbench

- Upstream stage of the PWM generator. Turns raw, asynchronous, bouncy increase/decrease switch inputs into clean single-cycle step pulses on the generator's swt_increase / swt_decrease inputs.
- Per channel: synchroniser, debounce filter, edge-to-pulse converter and optional hold-to-repeat.
- A cross-channel lockout suppresses steps while both switches are held.

---
 rtl/pwm_switch_conditioner.sv | 154 +++++++++++++++
 tb/tb_pwm_switch_conditioner.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_switch_conditioner.sv
// Cleans raw increase/decrease switches into one-cycle step pulses for the PWM generator.
// Press-to-pulse latency is SYNC_STAGES+DEBOUNCE_CYCLES+1 edges; holding both switches locks out all steps.
module pwm_switch_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic swt_increase_raw,
  input  logic swt_decrease_raw,
  output logic swt_increase,
  output logic swt_decrease,
  output logic conflict
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE    = DW'(1);
  localparam logic [RW-1:0] DELAY_LAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RATE_LAST  = RW'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);
  localparam logic [RW-1:0] REP_ONE    = RW'(1);
  localparam logic [RW-1:0] REP_SAT    = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Index 0 is the increase channel, index 1 the decrease channel.
  logic [1:0]             w_raw;
  logic [SYNC_STAGES-1:0] r_sync [2];
  logic [1:0]             w_sync;
  logic [1:0]             r_deb;
  logic [1:0]             w_other;
  logic [DW-1:0]          r_deb_cnt [2];
  state_t                 r_state [2];
  state_t                 w_state_nxt [2];
  logic [RW-1:0]          r_rep_cnt [2];
  logic [RW-1:0]          w_rep_cnt_nxt [2];
  logic [1:0]             r_rep_run;
  logic [1:0]             w_rep_run_nxt;
  logic [1:0]             r_pulse;
  logic [1:0]             w_pulse_nxt;
  logic                   r_conflict;

  assign w_raw   = {swt_decrease_raw, swt_increase_raw};
  assign w_sync  = {r_sync[1][SYNC_STAGES-1], r_sync[0][SYNC_STAGES-1]};
  assign w_other = {r_deb[0], r_deb[1]};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        r_sync[i] <= '0;
      end else begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
      end
    end
  end

  // The debounced level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        r_deb[i]     <= 1'b0;
        r_deb_cnt[i] <= '0;
      end else if (w_sync[i] == r_deb[i]) begin
        r_deb_cnt[i] <= '0;
      end else if (r_deb_cnt[i] == DEB_LAST) begin
        r_deb[i]     <= ~r_deb[i];
        r_deb_cnt[i] <= '0;
      end else begin
        r_deb_cnt[i] <= r_deb_cnt[i] + DEB_ONE;
      end
    end
  end

  // r_rep_run marks that the first repeat has fired, so later repeats use REPEAT_RATE.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_state_nxt[i]   = r_state[i];
      w_rep_cnt_nxt[i] = r_rep_cnt[i];
      w_rep_run_nxt[i] = r_rep_run[i];
      w_pulse_nxt[i]   = 1'b0;
      case (r_state[i])
        ST_IDLE: begin
          if (r_deb[i]) begin
            if (w_other[i]) begin
              w_state_nxt[i] = ST_LOCKED;
            end else begin
              w_state_nxt[i]   = ST_HOLD;
              w_pulse_nxt[i]   = 1'b1;
              w_rep_cnt_nxt[i] = '0;
              w_rep_run_nxt[i] = 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (!r_deb[i]) begin
            w_state_nxt[i] = ST_IDLE;
          end else if (w_other[i]) begin
            w_state_nxt[i] = ST_LOCKED;
          end else if (REPEAT_DELAY > 0) begin
            if (r_rep_cnt[i] == (r_rep_run[i] ? RATE_LAST : DELAY_LAST)) begin
              w_pulse_nxt[i]   = 1'b1;
              w_rep_cnt_nxt[i] = '0;
              w_rep_run_nxt[i] = 1'b1;
            end else if (r_rep_cnt[i] != REP_SAT) begin
              w_rep_cnt_nxt[i] = r_rep_cnt[i] + REP_ONE;
            end
          end
        end
        ST_LOCKED: begin
          if (!r_deb[i]) begin
            w_state_nxt[i] = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt[i] = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_state[i]   <= ST_IDLE;
        r_rep_cnt[i] <= '0;
      end
      r_rep_run  <= '0;
      r_pulse    <= '0;
      r_conflict <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_state[i]   <= w_state_nxt[i];
        r_rep_cnt[i] <= w_rep_cnt_nxt[i];
      end
      r_rep_run  <= w_rep_run_nxt;
      r_pulse    <= w_pulse_nxt;
      r_conflict <= r_deb[0] & r_deb[1];
    end
  end

  assign swt_increase = r_pulse[0];
  assign swt_decrease = r_pulse[1];
  assign conflict     = r_conflict;

endmodule

// File: tb/tb_pwm_switch_conditioner.sv
// Drives two conditioners (default timing and short repeat timing) and checks them against a behavioural model.
module tb_pwm_switch_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int RD0  = 50000000;
  localparam int RR0  = 10000000;
  localparam int RD1  = 20;
  localparam int RR1  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inc_raw;
  logic       dec_raw;
  logic [1:0] o_inc;
  logic [1:0] o_dec;
  logic [1:0] o_cf;

  int n_chk  = 0;
  int n_fail = 0;

  pwm_switch_conditioner u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .swt_increase_raw (inc_raw),
    .swt_decrease_raw (dec_raw),
    .swt_increase     (o_inc[0]),
    .swt_decrease     (o_dec[0]),
    .conflict         (o_cf[0])
  );

  pwm_switch_conditioner #(
    .REPEAT_DELAY (RD1),
    .REPEAT_RATE  (RR1)
  ) u_dut_rep (
    .clk              (clk),
    .rst_n            (rst_n),
    .swt_increase_raw (inc_raw),
    .swt_decrease_raw (dec_raw),
    .swt_increase     (o_inc[1]),
    .swt_decrease     (o_dec[1]),
    .conflict         (o_cf[1])
  );

  always #5 clk = ~clk;

  // Model state: sampled raw history since reset, debounced levels, and per-instance hold bookkeeping.
  bit m_hist [2][16];
  bit m_deb  [2];
  int m_since;
  int m_hold [2][2];
  bit m_lock [2][2];
  bit e_pulse [2][2];
  bit e_cf;
  int abs_edge  = 0;
  int scen_edge = 0;

  int pcnt  [2][2];
  int pedge [2][2][8];
  int cf_cnt;
  int cf_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (scenario edge %0d)", tag, obs, exp, scen_edge);
    end
  endtask

  task automatic model_edge(input bit inc, input bit dec, input bit rn);
    bit raw [2];
    bit nd  [2];
    bit own, oth, tog, smp;
    int d, rd, rr;
    raw[0] = inc;
    raw[1] = dec;
    if (!rn) begin
      m_since = 0;
      e_cf    = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_deb[i] = 1'b0;
        for (int a = 0; a < 16; a++) m_hist[i][a] = 1'b0;
        for (int m = 0; m < 2; m++) begin
          m_hold[m][i]  = -1;
          m_lock[m][i]  = 1'b0;
          e_pulse[m][i] = 1'b0;
        end
      end
      return;
    end
    e_cf = m_deb[0] & m_deb[1];
    // Pulses: first pulse when a press is accepted alone, repeats at fixed offsets from it.
    for (int m = 0; m < 2; m++) begin
      rd = (m == 0) ? RD0 : RD1;
      rr = (m == 0) ? RR0 : RR1;
      for (int i = 0; i < 2; i++) begin
        own = m_deb[i];
        oth = m_deb[1-i];
        e_pulse[m][i] = 1'b0;
        if (m_hold[m][i] >= 0) begin
          if (!own) begin
            m_hold[m][i] = -1;
          end else if (oth) begin
            m_hold[m][i] = -1;
            m_lock[m][i] = 1'b1;
          end else if (rd != 0) begin
            d = abs_edge - m_hold[m][i];
            if (d >= rd && ((d - rd) % rr) == 0) e_pulse[m][i] = 1'b1;
          end
        end else if (m_lock[m][i]) begin
          if (!own) m_lock[m][i] = 1'b0;
        end else if (own) begin
          if (oth) begin
            m_lock[m][i] = 1'b1;
          end else begin
            m_hold[m][i]  = abs_edge;
            e_pulse[m][i] = 1'b1;
          end
        end
      end
    end
    // Debounce: level flips when the last DEB synchronised samples (all post-reset) disagree with it.
    m_since++;
    for (int i = 0; i < 2; i++) begin
      for (int a = 15; a > 0; a--) m_hist[i][a] = m_hist[i][a-1];
      m_hist[i][0] = raw[i];
      tog = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        smp = ((j + SYNC) < m_since) ? m_hist[i][j+SYNC] : 1'b0;
        if (j >= m_since || smp == m_deb[i]) tog = 1'b0;
      end
      nd[i] = tog ? ~m_deb[i] : m_deb[i];
    end
    m_deb[0] = nd[0];
    m_deb[1] = nd[1];
  endtask

  task automatic rec(input int m, input int o);
    if (pcnt[m][o] < 8) pedge[m][o][pcnt[m][o]] = scen_edge;
    pcnt[m][o]++;
  endtask

  task automatic step(input bit inc, input bit dec, input bit rn);
    inc_raw = inc;
    dec_raw = dec;
    rst_n   = rn;
    @(posedge clk);
    abs_edge++;
    scen_edge++;
    model_edge(inc, dec, rn);
    @(negedge clk);
    chk("inc_def", 32'(o_inc[0]), 32'(e_pulse[0][0]));
    chk("dec_def", 32'(o_dec[0]), 32'(e_pulse[0][1]));
    chk("cf_def",  32'(o_cf[0]),  32'(e_cf));
    chk("inc_rep", 32'(o_inc[1]), 32'(e_pulse[1][0]));
    chk("dec_rep", 32'(o_dec[1]), 32'(e_pulse[1][1]));
    chk("cf_rep",  32'(o_cf[1]),  32'(e_cf));
    chk("excl_def", 32'(o_inc[0] & o_dec[0]), 32'd0);
    chk("excl_rep", 32'(o_inc[1] & o_dec[1]), 32'd0);
    for (int m = 0; m < 2; m++) begin
      if (o_inc[m] === 1'b1) rec(m, 0);
      if (o_dec[m] === 1'b1) rec(m, 1);
    end
    if (o_cf[0] === 1'b1) begin
      cf_cnt++;
      if (cf_first < 0) cf_first = scen_edge;
    end
  endtask

  task automatic scen_start();
    scen_edge = 0;
    cf_cnt    = 0;
    cf_first  = -1;
    for (int m = 0; m < 2; m++) begin
      for (int o = 0; o < 2; o++) begin
        pcnt[m][o] = 0;
        for (int k = 0; k < 8; k++) pedge[m][o][k] = -1;
      end
    end
  endtask

  initial begin
    int exp3 [5];
    int cnt;
    int r;
    bit lv;
    bit lvl [2];
    int rem [2];
    bit rn;

    scen_start();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0);
    chk("rst_inc_def", 32'(o_inc[0]), 32'd0);
    chk("rst_dec_def", 32'(o_dec[0]), 32'd0);
    chk("rst_cf_def",  32'(o_cf[0]),  32'd0);
    chk("rst_inc_rep", 32'(o_inc[1]), 32'd0);
    chk("rst_dec_rep", 32'(o_dec[1]), 32'd0);
    chk("rst_cf_rep",  32'(o_cf[1]),  32'd0);

    // Single press, 10 cycles.
    scen_start();
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 30; k++) step(1'b0, 1'b0, 1'b1);
    chk("t1_inc_cnt",  pcnt[0][0], 1);
    chk("t1_inc_edge", pedge[0][0][0], 7);
    chk("t1_dec_cnt",  pcnt[0][1], 0);
    chk("t1_cf_cnt",   cf_cnt, 0);
    chk("t1_rep_cnt",  pcnt[1][0], 1);

    // Bounce with periods of 1..3 cycles.
    scen_start();
    cnt = 0;
    lv  = 1'b1;
    while (cnt < 40) begin
      r = int'($urandom_range(1, 3));
      for (int k = 0; k < r && cnt < 40; k++) begin
        step(1'b0, lv, 1'b1);
        cnt++;
      end
      lv = ~lv;
    end
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b1);
    chk("t2_dec_def", pcnt[0][1], 0);
    chk("t2_dec_rep", pcnt[1][1], 0);
    chk("t2_inc_def", pcnt[0][0], 0);

    // Long hold with auto-repeat.
    scen_start();
    for (int k = 0; k < 50; k++) step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 30; k++) step(1'b0, 1'b0, 1'b1);
    exp3[0] = 7;
    exp3[1] = 27;
    exp3[2] = 35;
    exp3[3] = 43;
    exp3[4] = 51;
    chk("t3_rep_cnt", pcnt[1][0], 5);
    for (int k = 0; k < 5; k++) chk("t3_rep_edge", pedge[1][0][k], exp3[k]);
    chk("t3_def_cnt", pcnt[0][0], 1);

    // Both pressed together, then decrease alone stays locked until re-pressed.
    scen_start();
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b1);
    chk("t4_inc_cnt", pcnt[0][0], 0);
    chk("t4_dec_cnt", pcnt[0][1], 0);
    chk("t4_cf_cnt",  cf_cnt, 10);
    chk("t4_cf_first", cf_first, 7);
    scen_start();
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b1);
    chk("t4_repress_cnt",  pcnt[0][1], 1);
    chk("t4_repress_edge", pedge[0][1][0], 7);

    // Decrease pressed during an increase hold.
    scen_start();
    for (int k = 0; k < 15; k++) step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 35; k++) step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 30; k++) step(1'b0, 1'b0, 1'b1);
    chk("t5_inc_def", pcnt[0][0], 1);
    chk("t5_dec_def", pcnt[0][1], 0);
    chk("t5_inc_rep", pcnt[1][0], 1);
    chk("t5_dec_rep", pcnt[1][1], 0);

    // Reset in the middle of debouncing a press.
    scen_start();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b1);
    chk("t6_inc_cnt",  pcnt[0][0], 1);
    chk("t6_inc_edge", pedge[0][0][0], 12);
    chk("t6_rep_cnt",  pcnt[1][0], 1);

    // Random presses, bounces, overlaps and occasional resets.
    scen_start();
    lvl[0] = 1'b0;
    lvl[1] = 1'b0;
    rem[0] = 5;
    rem[1] = 9;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (rem[i] == 0) begin
          lvl[i] = ~lvl[i];
          if ($urandom_range(0, 3) == 0) rem[i] = int'($urandom_range(1, 3));
          else                           rem[i] = int'($urandom_range(4, 70));
        end
        rem[i]--;
      end
      rn = ($urandom_range(0, 299) != 0);
      step(lvl[0], lvl[1], rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
